// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer with IF/ID register and one-entry skid buffer
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_d_o,
  output logic [31:0] pcplus4_d_o,
  output logic        valid_d_o
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, fetch_pc, fetch_pc_n, skid_instr, skid_pc;
  logic if_free, load_mem, load_skid, skid_cap;
  assign imem_addr_o = {pc[31:2], 2'b00};
  // next-state, next-PC and request decode; redirect always wins over grant and response
  always_comb begin
    state_n = state;
    pc_n = pc;
    fetch_pc_n = fetch_pc;
    imem_req_o = 1'b0;
    load_mem = 1'b0;
    load_skid = 1'b0;
    skid_cap = 1'b0;
    if_free = !valid_d_o || !stall_d_i;
    case (state)
      REQ: begin
        imem_req_o = rst;
        if (redirect_i) begin
          pc_n = redirect_pc_i;
          if (imem_gnt_i) begin
            fetch_pc_n = pc;
            state_n = DISCARD;
          end
        end else if (imem_gnt_i) begin
          fetch_pc_n = pc;
          pc_n = pc + 32'd4;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          pc_n = redirect_pc_i;
          state_n = imem_rvalid_i ? REQ : DISCARD;
        end else if (flush_d_i) begin
          state_n = imem_rvalid_i ? REQ : DISCARD;
        end else if (imem_rvalid_i && if_free) begin
          load_mem = 1'b1;
          imem_req_o = 1'b1;
          if (imem_gnt_i) begin
            fetch_pc_n = pc;
            pc_n = pc + 32'd4;
          end else begin
            state_n = REQ;
          end
        end else if (imem_rvalid_i) begin
          skid_cap = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        pc_n = redirect_i ? redirect_pc_i : pc;
        load_skid = !flush_d_i && !stall_d_i;
        state_n = (flush_d_i || !stall_d_i) ? REQ : HOLD;
      end
      default: begin
        pc_n = redirect_i ? redirect_pc_i : pc;
        state_n = imem_rvalid_i ? REQ : DISCARD;
      end
    endcase
  end
  // state, fetch PCs and skid buffer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= REQ;
      pc <= RESET_PC;
      fetch_pc <= RESET_PC;
      skid_instr <= '0;
      skid_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fetch_pc <= fetch_pc_n;
      if (skid_cap) begin
        skid_instr <= imem_rdata_i;
        skid_pc <= fetch_pc;
      end
    end
  // IF/ID register: flush beats load beats stall; an idle unstalled cycle becomes a bubble
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      instr_d_o <= '0;
      pc_d_o <= '0;
      pcplus4_d_o <= '0;
      valid_d_o <= 1'b0;
    end else if (flush_d_i) begin
      instr_d_o <= NOP_INSTR;
      valid_d_o <= 1'b0;
    end else if (load_mem) begin
      instr_d_o <= imem_rdata_i;
      pc_d_o <= fetch_pc;
      pcplus4_d_o <= fetch_pc + 32'd4;
      valid_d_o <= 1'b1;
    end else if (load_skid) begin
      instr_d_o <= skid_instr;
      pc_d_o <= skid_pc;
      pcplus4_d_o <= skid_pc + 32'd4;
      valid_d_o <= 1'b1;
    end else if (!stall_d_i) begin
      valid_d_o <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: vector table, latency/redirect/reset sequences and randomized run against a stream model
module tb_fetch_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic redirect_i = 1'b0, stall_d_i = 1'b0, flush_d_i = 1'b0, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic imem_req_o, valid_d_o;
  logic [31:0] imem_addr_o, instr_d_o, pc_d_o, pcplus4_d_o;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_d_i(stall_d_i), .flush_d_i(flush_d_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_d_o(instr_d_o), .pc_d_o(pc_d_o), .pcplus4_d_o(pcplus4_d_o), .valid_d_o(valid_d_o)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct {
    bit st; bit fl; bit rd; logic [31:0] tgt;
    bit req; logic [31:0] addr; bit v; logic [31:0] pc; logic [31:0] ins;
  } vec_t;

  pend_t pend[$];
  vec_t vec[20];
  int checks = 0, failures = 0, cyc = 0, gnt_pct = 100, lat_lo = 1, lat_hi = 1;
  int consumed = 0, last_g = -1, gap_exp = 0;
  bit model_on = 0, s_req;
  logic [31:0] exp_pc = '0, s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: drive inputs and the memory responder, sample pre-edge, update the stream model
  task automatic tick(input bit st, input bit fl, input bit rd, input logic [31:0] tgt);
    bit rv, g, v;
    logic [31:0] pcd, ins, p4;
    stall_d_i = st; flush_d_i = fl; redirect_i = rd; redirect_pc_i = tgt;
    rv = pend.size() > 0 && pend[0].due <= cyc;
    imem_rvalid_i = rv;
    imem_rdata_i = rv ? mem_word(pend[0].addr) : 32'hDEADBEEF;
    imem_gnt_i = $urandom_range(99) < gnt_pct;
    #1;
    g = imem_req_o && imem_gnt_i;
    s_req = imem_req_o; s_addr = imem_addr_o;
    v = valid_d_o; pcd = pc_d_o; ins = instr_d_o; p4 = pcplus4_d_o;
    if (g) chk(pend.size() == int'(rv), "one outstanding", pend.size(), int'(rv));
    if (g && gap_exp > 0 && last_g >= 0) chk(cyc - last_g == gap_exp, "request spacing", cyc - last_g, gap_exp);
    if (g) last_g = cyc;
    if (model_on) begin
      if (rd) exp_pc = tgt;
      else if (v && !st) begin
        chk(pcd == exp_pc && ins == mem_word(exp_pc) && p4 == exp_pc + 32'd4, "decode stream", pcd, exp_pc);
        exp_pc += 32'd4;
        consumed++;
      end
    end
    @(posedge clk);
    #1;
    if (rv) pend.delete(0);
    if (g) pend.push_back('{ga_of(s_addr), cyc + $urandom_range(lat_hi, lat_lo)});
    cyc++;
  endtask

  function automatic logic [31:0] ga_of(input logic [31:0] a);
    return a;
  endfunction

  task automatic do_reset(input bit keep);
    #2 rst = 1'b0;
    #1;
    chk(imem_req_o == 1'b0, "reset req", imem_req_o, 0);
    chk(!valid_d_o && instr_d_o == 0 && pc_d_o == 0 && pcplus4_d_o == 0, "reset outputs",
        instr_d_o | pc_d_o | pcplus4_d_o | {31'b0, valid_d_o}, 0);
    if (!keep) pend.delete();
    stall_d_i = 0; flush_d_i = 0; redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_pc = 32'h0;
    last_g = -1;
  endtask

  initial begin
    bit seen;
    int st_left;
    vec = '{
      '{0,0,0,32'h0,   1,32'h0,   0,32'h0,   32'h0},
      '{0,0,0,32'h0,   1,32'h4,   1,32'h0,   32'h10000000},
      '{0,0,0,32'h0,   1,32'h8,   1,32'h4,   32'h10000001},
      '{1,0,0,32'h0,   0,32'h0,   1,32'h4,   32'h10000001},
      '{1,0,0,32'h0,   0,32'h0,   1,32'h4,   32'h10000001},
      '{0,0,0,32'h0,   0,32'h0,   1,32'h8,   32'h10000002},
      '{0,0,0,32'h0,   1,32'hC,   0,32'h8,   32'h10000002},
      '{0,0,0,32'h0,   1,32'h10,  1,32'hC,   32'h10000003},
      '{0,1,1,32'h200, 0,32'h0,   0,32'hC,   32'h13},
      '{0,0,0,32'h0,   1,32'h200, 0,32'hC,   32'h13},
      '{0,0,0,32'h0,   1,32'h204, 1,32'h200, 32'h10000080},
      '{0,0,0,32'h0,   1,32'h208, 1,32'h204, 32'h10000081},
      '{1,1,0,32'h0,   0,32'h0,   0,32'h204, 32'h13},
      '{0,0,0,32'h0,   1,32'h20C, 0,32'h204, 32'h13},
      '{0,0,0,32'h0,   1,32'h210, 1,32'h20C, 32'h10000083},
      '{1,0,0,32'h0,   0,32'h0,   1,32'h20C, 32'h10000083},
      '{1,1,0,32'h0,   0,32'h0,   0,32'h20C, 32'h13},
      '{0,0,0,32'h0,   1,32'h214, 0,32'h20C, 32'h13},
      '{0,0,0,32'h0,   1,32'h218, 1,32'h214, 32'h10000085},
      '{0,0,0,32'h0,   1,32'h21C, 1,32'h218, 32'h10000086}
    };
    do_reset(0);
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick(vec[i].st, vec[i].fl, vec[i].rd, vec[i].tgt);
      chk(s_req == vec[i].req && (!vec[i].req || s_addr == vec[i].addr), $sformatf("vec%0d req/addr", i),
          {s_req, s_addr[30:0]}, {vec[i].req, vec[i].addr[30:0]});
      chk(valid_d_o == vec[i].v, $sformatf("vec%0d valid", i), valid_d_o, vec[i].v);
      chk(pc_d_o == vec[i].pc, $sformatf("vec%0d pc_d", i), pc_d_o, vec[i].pc);
      chk(instr_d_o == vec[i].ins, $sformatf("vec%0d instr_d", i), instr_d_o, vec[i].ins);
    end
    // slow memory: response 4 cycles after grant, one request per 4 cycles
    do_reset(0);
    lat_lo = 4; lat_hi = 4; gap_exp = 4; model_on = 1; consumed = 0;
    repeat (14) tick(0, 0, 0, 0);
    chk(consumed == 3, "slow mem deliveries", consumed, 3);
    gap_exp = 0;
    // redirect near the top of the address space and wrap
    lat_lo = 1; lat_hi = 1; seen = 0;
    tick(0, 1, 1, 32'hFFFFFFFC);
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0);
      if (valid_d_o && pc_d_o == 32'hFFFFFFFC && !seen) begin
        chk(pcplus4_d_o == 32'h0, "wrap pcplus4", pcplus4_d_o, 0);
        seen = 1;
      end
    end
    chk(seen == 1'b1, "wrap entry seen", seen, 1);
    chk(exp_pc >= 32'h4 && exp_pc < 32'h100, "wrap continues at 0", exp_pc, 32'h4);
    // reset while a slow request is in flight; its late response must be ignored
    lat_lo = 5; lat_hi = 5;
    for (int i = 0; i < 10 && pend.size() == 0; i++) tick(0, 0, 0, 0);
    while (pend.size() > 0 && pend[0].due <= cyc) tick(0, 0, 0, 0);
    for (int i = 0; i < 10 && pend.size() == 0; i++) tick(0, 0, 0, 0);
    chk(pend.size() == 1, "in flight before reset", pend.size(), 1);
    do_reset(1);
    gnt_pct = 0;
    for (int i = 0; i < 8 && pend.size() > 0; i++) begin
      tick(0, 0, 0, 0);
      chk(s_req && s_addr == 32'h0, "req RESET_PC", s_addr, 0);
      chk(valid_d_o == 1'b0, "stale response ignored", valid_d_o, 0);
    end
    chk(pend.size() == 0, "stale response drained", pend.size(), 0);
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk(valid_d_o && pc_d_o == 32'h0 && instr_d_o == 32'h10000000, "first fetch after reset", pc_d_o, 0);
    // randomized traffic: variable grant/latency, stall bursts, redirects with flush
    gnt_pct = 60; lat_lo = 1; lat_hi = 3; consumed = 0; st_left = 0;
    for (int i = 0; i < 600; i++) begin
      bit st, rd;
      if (st_left > 0) begin
        st = 1; st_left--;
      end else begin
        st = 0;
        if ($urandom_range(9) == 0) st_left = $urandom_range(5, 1);
      end
      rd = $urandom_range(24) == 0;
      tick(st, rd, rd, $urandom & 32'hFFFFFFFC);
    end
    chk(consumed >= 40, "random throughput", consumed, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch against a handshaked, variable-latency instruction memory port.
- Owns the fetch PC, the IF/ID pipeline register and a one-entry skid buffer.
- Applies execute-stage redirects (taken branch or jump) and decode-stage stall and flush.
- Sits between the hazard unit, the execute stage and the instruction memory; it feeds the decode stage.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000013, instruction driven to decode on flush (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
redirect_i  input  1  execute-stage redirect request (PCSrcE)
redirect_pc_i  input  32  redirect target (PCTargetE)
stall_d_i  input  1  decode stall; hold the IF/ID register
flush_d_i  input  1  decode flush; invalidate the IF/ID register and the skid buffer
imem_req_o  output  1  memory read request
imem_addr_o  output  32  request address, word aligned
imem_gnt_i  input  1  request accepted in this cycle
imem_rvalid_i  input  1  read data valid; arrives at least 1 cycle after the grant
imem_rdata_i  input  32  read data
instr_d_o  output  32  IF/ID instruction (InstrD)
pc_d_o  output  32  IF/ID PC (PCD)
pcplus4_d_o  output  32  IF/ID PC+4 (PCPlus4D)
valid_d_o  output  1  IF/ID entry valid

Behaviour:
Reset (rst=0, asynchronous):
- state=REQ, pc=RESET_PC, fetch_pc=RESET_PC.
- Skid buffer empty; instr_d_o, pc_d_o, pcplus4_d_o and valid_d_o all 0.
- imem_req_o=0 while rst=0.
- A reset mid-transaction abandons it; a late rvalid arriving in REQ is ignored.

Registers:
- pc is the next fetch address.
- fetch_pc is the address of the request in flight. It is captured on every grant.
- All PC arithmetic is mod 2^32; 32'hFFFFFFFC+4 wraps to 0.

States:
- REQ:
  - imem_req_o=1, imem_addr_o=pc.
  - redirect_i=1 sets pc=redirect_pc_i; the address may change before a grant only for a redirect.
  - On gnt with no redirect: fetch_pc=pc, pc=pc+4, go to WAIT.
  - Redirect has priority over a grant in the same cycle: treat the grant as issued, capture the address, go to DISCARD.
- WAIT (one outstanding request):
  - redirect_i=1 sets pc=redirect_pc_i and goes to DISCARD. If rvalid arrives in the same cycle, drop it and go to REQ.
  - On rvalid with the IF/ID register free (valid_d_o=0 or stall_d_i=0): load IF/ID with {rdata, fetch_pc, fetch_pc+4}, valid=1.
  - In that same cycle, back-to-back issue imem_req_o=1 with addr=pc.
  - If that request is granted, set fetch_pc=pc, pc=pc+4, stay in WAIT. Otherwise go to REQ.
  - On rvalid with the IF/ID register stalled: capture into the skid buffer, go to HOLD, no new request.
- HOLD:
  - imem_req_o=0.
  - When stall_d_i=0: skid moves into IF/ID, the skid empties, go to REQ.
- DISCARD:
  - imem_req_o=0.
  - The next rvalid is dropped, then go to REQ.
  - A further redirect only updates pc.

IF/ID register:
- stall_d_i=1 holds the register unless flush_d_i=1.
- flush_d_i=1 has priority over stall and over a load:
  - valid_d_o=0, instr_d_o=NOP_INSTR.
  - Skid cleared; HOLD goes to REQ.
  - A response arriving in the same cycle is dropped. In WAIT the state goes to DISCARD-equivalent handling, i.e. the data is not loaded.
- With no load, no stall and no flush: valid_d_o clears to 0 (a bubble). instr_d_o, pc_d_o and pcplus4_d_o hold their values.

Latency and throughput:
- With a zero-wait memory (gnt in the request cycle, rvalid the next cycle), the first instruction reaches IF/ID 2 cycles after reset deasserts.
- Steady-state throughput is 1 instruction per cycle.
- A redirect costs a minimum of 2 bubble cycles.
- No more than one request is ever outstanding.

Test Plan:
1. Zero-wait memory, memory holds word i = 0x1000_0000+i, no stalls → valid_d_o=1 from cycle 2 onward; pc_d_o=0,4,8,…; instr_d_o=0x10000000,0x10000001,…; one instruction per cycle.
2. Memory with 3-cycle rvalid latency → imem_req_o pulses once per 4 cycles with addresses 0,4,8; never more than 1 outstanding; IF/ID receives each word with matching pc_d_o/pcplus4_d_o.
3. stall_d_i=1 for 5 cycles while a response arrives → skid captures the response, imem_req_o=0 during HOLD; after the stall releases, the instruction appears exactly once, in order, with no loss or duplication.
4. Redirect to 0x200 while in WAIT for address 0x10 → the 0x10 response is dropped; the next request address is 0x200; pc_d_o=0x200 and valid_d_o=1 appear with no 0x10 entry.
5. flush_d_i and stall_d_i both high, with a response in the skid → valid_d_o=0, instr_d_o=0x00000013, skid empty, controller back in REQ the next cycle.
6. Redirect to 0xFFFFFFFC, then sequential fetch; plus rst asserted mid-WAIT → next pc after 0xFFFFFFFC is 0x0; on reset all outputs read 0 and the first request after release is to RESET_PC.
